// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Imported by the arbiter top and by its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin search: the first valid index after i_last, with wrap.
// The search is purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_last,
    output logic          o_found,
    output logic [IW-1:0] o_index
);

    logic [IW:0] w_pos;

    // The loop runs from the farthest offset down to the nearest one.
    // The nearest valid requester is assigned last, so it wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = N; k >= 1; k--) begin
            w_pos = {1'b0, i_last} + k[IW:0];
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (i_valid[w_pos[IW-1:0]]) begin
                o_found = 1'b1;
                o_index = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates several requesters onto one FIFO write port.
// Each grant is a burst of up to MAX_BURST beats, served in round-robin order.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    localparam int IW = $clog2(NUM_REQ),
    localparam int BW = $clog2(MAX_BURST) + 1
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_t    r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic [BW-1:0] r_beat;

    logic          w_found;
    logic [IW-1:0] w_pick;
    logic          w_burst;
    logic          w_gvalid;
    logic          w_wen;
    logic          w_last_beat;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_found (w_found),
        .o_index (w_pick)
    );

    // Reset gates all outputs so an abandoned burst never writes.
    assign w_burst     = (r_state == BURST) && !w_rst;
    assign w_gvalid    = req_valid[r_grant];
    assign w_wen       = w_burst && w_gvalid && !fifo_full;
    assign w_last_beat = (r_beat == BW'(MAX_BURST - 1));

    assign fifo_w_en = w_wen;
    assign busy      = w_burst;
    assign grant_id  = r_grant;

    always_comb begin
        req_ready = '0;
        if (w_burst) begin
            req_ready[r_grant] = !fifo_full;
        end
    end

    always_comb begin
        fifo_w_data = '0;
        if (w_burst) begin
            fifo_w_data = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_beat  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_beat  <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (!w_gvalid) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end else if (!fifo_full) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_last  <= r_grant;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with hand-computed expectations.
// Covers grant order, stalls, early exit and reset in the middle of a burst.
module tb_fifo_write_arbiter;

    logic        w_clk;
    logic        w_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_w_data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks;
    int failures;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wen"}, 32'(fifo_w_en), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_data"}, 32'(fifo_w_data), 32'd0);
    endtask

    task automatic chk_burst(input string tag, input int id,
                             input logic [7:0] d, input int beats);
        for (int b = 0; b < beats; b++) begin
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_gid"}, 32'(grant_id), 32'(id));
            chk({tag, "_wen"}, 32'(fifo_w_en), 32'd1);
            chk({tag, "_data"}, 32'(fifo_w_data), 32'(d));
            chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        w_rst     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'hD3C2B1A0;
        fifo_full = 1'b0;

        tick();
        tick();
        #1;
        chk("rst_wen", 32'(fifo_w_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        w_rst = 1'b0;

        // single requester: one IDLE cycle, then four writes
        req_valid = 4'b0001;
        chk_idle("s1_arb");
        tick();
        chk_burst("s1", 0, 8'hA0, 4);
        req_valid = 4'b0000;
        chk_idle("s1_end");
        tick();
        chk_idle("s1_stay");
        chk("s1_gid_hold", 32'(grant_id), 32'd0);

        // all requesters: order 0,1,2,3,0 starting from reset priority
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        req_valid = 4'b1111;
        chk_idle("s2_arb");
        tick();
        chk_burst("s2_g0", 0, 8'hA0, 4);
        chk_idle("s2_gap0");
        tick();
        chk_burst("s2_g1", 1, 8'hB1, 4);
        chk_idle("s2_gap1");
        tick();
        chk_burst("s2_g2", 2, 8'hC2, 4);
        chk_idle("s2_gap2");
        tick();
        chk_burst("s2_g3", 3, 8'hD3, 4);
        chk_idle("s2_gap3");
        tick();
        chk_burst("s2_g0b", 0, 8'hA0, 4);
        req_valid = 4'b0000;
        chk_idle("s2_end");
        tick();

        // requester 2, FIFO full for three cycles after beat 1
        req_valid = 4'b0100;
        chk_idle("s3_arb");
        tick();
        chk_burst("s3_b1", 2, 8'hC2, 1);
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("s3_stall_wen", 32'(fifo_w_en), 32'd0);
            chk("s3_stall_ready", 32'(req_ready), 32'd0);
            chk("s3_stall_busy", 32'(busy), 32'd1);
            chk("s3_stall_gid", 32'(grant_id), 32'd2);
            tick();
        end
        fifo_full = 1'b0;
        chk_burst("s3_rest", 2, 8'hC2, 3);
        req_valid = 4'b0000;
        chk_idle("s3_end");
        tick();

        // requester 1 drops after two beats; others toggle meanwhile
        req_valid = 4'b0010;
        chk_idle("s4_arb");
        tick();
        req_valid = 4'b1011;
        chk_burst("s4_g1", 1, 8'hB1, 2);
        req_valid = 4'b0101;
        #1;
        chk("s4_drop_wen", 32'(fifo_w_en), 32'd0);
        chk("s4_drop_busy", 32'(busy), 32'd1);
        chk("s4_drop_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_idle("s4_gap");
        tick();
        chk_burst("s4_g2", 2, 8'hC2, 4);
        req_valid = 4'b0000;
        chk_idle("s4_end");
        tick();

        // reset at beat 2 of requester 3's burst
        req_valid = 4'b1000;
        chk_idle("s5_arb");
        tick();
        chk_burst("s5_g3", 3, 8'hD3, 2);
        w_rst = 1'b1;
        #1;
        chk("s5_rst_wen", 32'(fifo_w_en), 32'd0);
        chk("s5_rst_ready", 32'(req_ready), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        tick();
        w_rst = 1'b0;
        req_valid = 4'b1001;
        chk_idle("s5_after");
        chk("s5_gid_rst", 32'(grant_id), 32'd0);
        tick();
        chk_burst("s5_g0", 0, 8'hA0, 4);
        req_valid = 4'b0000;
        chk_idle("s5_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
